// File: rtl/fb_scale_reader_pkg.sv
// Shared constants and types for the frame-buffer upscaling reader.
package fb_scale_reader_pkg;

  localparam int VGA_W = 640;
  localparam int VGA_H = 480;

  typedef enum logic [7:0] {
    COLOR_BLACK = 8'h00,
    COLOR_WHITE = 8'hFF,
    COLOR_RED   = 8'hE0,
    COLOR_GREEN = 8'h1C,
    COLOR_BLUE  = 8'h03,
    COLOR_GRAY  = 8'h92
  } rgb332_color_e;

  typedef struct packed {
    logic valid;
    logic in_win;
  } pix_flags_t;

  // Scale select 3 is not a supported factor and folds onto 2.
  function automatic logic [1:0] clamp_scale(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'd2 : sel;
  endfunction

endpackage

// File: rtl/fb_axis_counter.sv
// Axis counter with a 2**scale sub-divider; value advances by STEP on each sub-wrap.
module fb_axis_counter
  import fb_scale_reader_pkg::*;
#(
  parameter int W        = 15,
  parameter int STEP     = 1,
  parameter bit PRE_STEP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  input  logic [1:0]   scale,
  output logic [W-1:0] value
);

  logic [W-1:0] base_q, base_start, base_inc, base_next;
  logic [1:0]   sub_q, sub_start, sub_inc, sub_next, sub_limit;

  // Next-state and current-value selection; PRE_STEP lets the step apply to this cycle's value.
  always_comb begin
    case (scale)
      2'd0:    sub_limit = 2'd0;
      2'd1:    sub_limit = 2'd1;
      default: sub_limit = 2'd3;
    endcase
    base_start = clear ? '0 : base_q;
    sub_start  = clear ? 2'd0 : sub_q;
    if (sub_start == sub_limit) begin
      sub_inc  = 2'd0;
      base_inc = base_start + W'(STEP);
    end else begin
      sub_inc  = sub_start + 2'd1;
      base_inc = base_start;
    end
    sub_next = step ? sub_inc : sub_start;
    if (PRE_STEP) begin
      value     = step ? base_inc : base_start;
      base_next = value;
    end else begin
      value     = base_start;
      base_next = step ? base_inc : base_start;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      sub_q  <= 2'd0;
    end else begin
      base_q <= base_next;
      sub_q  <= sub_next;
    end
  end

endmodule

// File: rtl/fb_scale_reader.sv
// Maps VGA display positions onto an upscaled frame-buffer window and fetches pixels.
module fb_scale_reader
  import fb_scale_reader_pkg::*;
#(
  parameter int CAM_W    = 160,
  parameter int CAM_H    = 120,
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int OFFSET_X = 0,
  parameter int OFFSET_Y = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    pos_x,
  input  logic [8:0]    pos_y,
  input  logic          pos_valid,
  input  logic [1:0]    scale_sel,
  input  logic [DW-1:0] border_color,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_data,
  output logic [DW-1:0] pixel_out,
  output logic          pixel_valid
);

  logic [8:0]    prev_y;
  logic [1:0]    scale_q, scale_eff;
  logic          aligned;
  logic          new_line, frame_start, in_active, in_x, in_y, in_win;
  logic          y_above, col_clear, row_step;
  logic [13:0]   x_rel, y_rel;
  logic [12:0]   x_span, y_span;
  logic [AW-1:0] col, row_base, addr_next;
  pix_flags_t    stage1, stage2;

  // Decode line/frame edges, the scale in force and window membership of this position.
  always_comb begin
    new_line    = (pos_y != prev_y);
    frame_start = (pos_y == 9'd0) && (prev_y != 9'd0);
    scale_eff   = frame_start ? clamp_scale(scale_sel) : scale_q;
    x_span      = 13'(CAM_W) << scale_eff;
    y_span      = 13'(CAM_H) << scale_eff;
    x_rel       = {4'b0000, pos_x} - 14'(OFFSET_X);
    y_rel       = {5'b00000, pos_y} - 14'(OFFSET_Y);
    in_active   = pos_valid && ({3'b000, pos_x} < 13'(VGA_W)) && ({4'b0000, pos_y} < 13'(VGA_H));
    in_x        = !x_rel[13] && (x_rel[12:0] < x_span);
    in_y        = !y_rel[13] && (y_rel[12:0] < y_span);
    y_above     = !y_rel[13] && (y_rel != 14'd0);
    in_win      = in_active && (aligned || frame_start) && in_x && in_y;
    col_clear   = (x_rel == 14'd0);
    row_step    = new_line && in_y && y_above;
  end

  fb_axis_counter #(
    .W        (AW),
    .STEP     (1),
    .PRE_STEP (1'b0)
  ) u_x_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (col_clear),
    .step  (in_win),
    .scale (scale_eff),
    .value (col)
  );

  fb_axis_counter #(
    .W        (AW),
    .STEP     (CAM_W),
    .PRE_STEP (1'b1)
  ) u_y_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (frame_start),
    .step  (row_step),
    .scale (scale_eff),
    .value (row_base)
  );

  assign addr_next = row_base + col;

  // Track the previous line, latch the scale once per frame and note counter alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_y  <= 9'd0;
      scale_q <= 2'd0;
      aligned <= 1'b0;
    end else begin
      prev_y <= pos_y;
      if (frame_start) begin
        scale_q <= clamp_scale(scale_sel);
        aligned <= 1'b1;
      end
    end
  end

  // Stage 1: issue the RAM address (held outside the window) with its flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      stage1   <= '0;
    end else begin
      if (in_win) begin
        ram_addr <= addr_next;
      end
      stage1.valid  <= in_active;
      stage1.in_win <= in_win;
    end
  end

  // Stage 2: flags line up with the RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage2 <= '0;
    end else begin
      stage2 <= stage1;
    end
  end

  assign pixel_valid = stage2.valid;
  assign pixel_out   = stage2.valid ? (stage2.in_win ? ram_data : border_color)
                                    : DW'(COLOR_BLACK);

  // Address bound guard: the window geometry must keep reads inside the image.
  addr_bound: assert property (@(posedge clk) disable iff (rst)
                               (ram_addr <= AW'(CAM_W * CAM_H - 1)));

endmodule

// File: tb/tb_fb_scale_reader.sv
// Directed bench: default instance (A) and an offset window instance (B) share the stimulus.
module tb_fb_scale_reader;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam logic [DW-1:0] BORDER = 8'hE3;
  localparam int K_NONE   = 0;
  localparam int K_ZERO   = 1;
  localparam int K_BORDER = 2;
  localparam int K_ADDR   = 3;

  typedef struct {
    int x;
    int y;
    int ka;
    int aa;
    int kb;
    int ab;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    pos_x = '0;
  logic [8:0]    pos_y = '0;
  logic          pos_valid = 1'b0;
  logic [1:0]    scale_sel = 2'd0;
  logic [DW-1:0] border_color = BORDER;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a = '0, ram_data_b = '0;
  logic [DW-1:0] pixel_out_a, pixel_out_b;
  logic          pixel_valid_a, pixel_valid_b;

  int   checks = 0;
  int   errors = 0;
  exp_t e1 = '{0, 0, 0, 0, 0, 0};
  exp_t e2 = '{0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  fb_scale_reader dut_a (
    .clk          (clk),
    .rst          (rst),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_valid    (pos_valid),
    .scale_sel    (scale_sel),
    .border_color (border_color),
    .ram_addr     (ram_addr_a),
    .ram_data     (ram_data_a),
    .pixel_out    (pixel_out_a),
    .pixel_valid  (pixel_valid_a)
  );

  fb_scale_reader #(
    .OFFSET_X (100),
    .OFFSET_Y (50)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_valid    (pos_valid),
    .scale_sel    (scale_sel),
    .border_color (border_color),
    .ram_addr     (ram_addr_b),
    .ram_data     (ram_data_b),
    .pixel_out    (pixel_out_b),
    .pixel_valid  (pixel_valid_b)
  );

  // Frame-buffer content is a fixed function of the address.
  function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // Synchronous-read RAM models, one per instance.
  always @(posedge clk) begin
    ram_data_a <= ram_fn(ram_addr_a);
    ram_data_b <= ram_fn(ram_addr_b);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Address of the item issued one cycle ago, pixel of the item issued two cycles ago.
  task automatic checkOutput(input string name, input exp_t ea, input exp_t ep, input bit second,
                             input logic [AW-1:0] obs_addr, input logic [DW-1:0] obs_pix,
                             input logic obs_valid);
    int ka, aa, kp, ap;
    ka = second ? ea.kb : ea.ka;
    aa = second ? ea.ab : ea.aa;
    kp = second ? ep.kb : ep.ka;
    ap = second ? ep.ab : ep.aa;
    if (ka == K_ADDR)
      check_val($sformatf("%s addr (%0d,%0d)", name, ea.x, ea.y), 32'(obs_addr), 32'(aa));
    if (kp == K_ZERO) begin
      check_val($sformatf("%s valid (%0d,%0d)", name, ep.x, ep.y), 32'(obs_valid), 32'd0);
      check_val($sformatf("%s pixel (%0d,%0d)", name, ep.x, ep.y), 32'(obs_pix), 32'd0);
    end else if (kp == K_BORDER) begin
      check_val($sformatf("%s valid (%0d,%0d)", name, ep.x, ep.y), 32'(obs_valid), 32'd1);
      check_val($sformatf("%s border (%0d,%0d)", name, ep.x, ep.y), 32'(obs_pix), 32'(BORDER));
    end else if (kp == K_ADDR) begin
      check_val($sformatf("%s valid (%0d,%0d)", name, ep.x, ep.y), 32'(obs_valid), 32'd1);
      check_val($sformatf("%s pixel (%0d,%0d)", name, ep.x, ep.y), 32'(obs_pix),
                32'(ram_fn(AW'(ap))));
    end
  endtask

  // Check pending outputs, then present one position for one clock.
  task automatic applyStimulus(input int x, input int y, input logic v,
                               input int ka, input int aa, input int kb, input int ab);
    checkOutput("A", e1, e2, 1'b0, ram_addr_a, pixel_out_a, pixel_valid_a);
    checkOutput("B", e1, e2, 1'b1, ram_addr_b, pixel_out_b, pixel_valid_b);
    pos_x     = 10'(x);
    pos_y     = 9'(y);
    pos_valid = v;
    e2 = e1;
    e1 = '{x, y, ka, aa, kb, ab};
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, " A ram_addr"}, 32'(ram_addr_a), 32'd0);
    check_val({tag, " A pixel_valid"}, 32'(pixel_valid_a), 32'd0);
    check_val({tag, " A pixel_out"}, 32'(pixel_out_a), 32'd0);
    check_val({tag, " B ram_addr"}, 32'(ram_addr_b), 32'd0);
    check_val({tag, " B pixel_valid"}, 32'(pixel_valid_b), 32'd0);
    check_val({tag, " B pixel_out"}, 32'(pixel_out_b), 32'd0);
  endtask

  initial begin
    $display("[TB] fb_scale_reader directed run");
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Before any frame start the counters are unaligned: border or zero only.
    applyStimulus(5, 3, 1'b1, K_BORDER, 0, K_BORDER, 0);
    applyStimulus(6, 3, 1'b0, K_ZERO, 0, K_ZERO, 0);
    applyStimulus(0, 479, 1'b0, K_ZERO, 0, K_ZERO, 0);

    // Frame A, s=0.
    for (int x = 0; x <= 160; x++)
      applyStimulus(x, 0, 1'b1, (x < 160) ? K_ADDR : K_BORDER, x, K_BORDER, 0);
    applyStimulus(0, 1, 1'b1, K_ADDR, 160, K_BORDER, 0);
    applyStimulus(1, 1, 1'b1, K_ADDR, 161, K_BORDER, 0);
    for (int y = 2; y <= 49; y++)
      applyStimulus(0, y, 1'b1, K_ADDR, y * 160, K_BORDER, 0);
    for (int x = 0; x <= 262; x++)
      applyStimulus(x, 50, 1'b1, (x < 160) ? K_ADDR : K_BORDER, 8000 + x,
                    (x >= 100 && x < 260) ? K_ADDR : K_BORDER, x - 100);
    applyStimulus(0, 51, 1'b1, K_ADDR, 8160, K_BORDER, 0);
    applyStimulus(100, 51, 1'b1, K_NONE, 0, K_ADDR, 160);
    for (int y = 52; y <= 118; y++)
      applyStimulus(0, y, 1'b1, K_ADDR, y * 160, K_BORDER, 0);
    for (int x = 0; x <= 159; x++)
      applyStimulus(x, 119, 1'b1, K_ADDR, 19040 + x,
                    (x >= 100) ? K_ADDR : K_BORDER, 11040 + x - 100);
    applyStimulus(0, 120, 1'b1, K_BORDER, 0, K_BORDER, 0);
    for (int y = 121; y <= 170; y++)
      applyStimulus(100, y, 1'b1, K_BORDER, 0, (y < 170) ? K_ADDR : K_BORDER, (y - 50) * 160);
    for (int y = 171; y <= 199; y++)
      applyStimulus(0, y, 1'b1, K_BORDER, 0, K_BORDER, 0);
    scale_sel = 2'd1;
    applyStimulus(0, 200, 1'b1, K_BORDER, 0, K_BORDER, 0);
    applyStimulus(5, 201, 1'b1, K_BORDER, 0, K_BORDER, 0);
    applyStimulus(0, 479, 1'b0, K_ZERO, 0, K_ZERO, 0);

    // Frame B, s=1 latched at frame start; a select of 3 arrives mid-frame.
    for (int x = 0; x <= 321; x++)
      applyStimulus(x, 0, 1'b1, (x < 320) ? K_ADDR : K_BORDER, x >> 1, K_BORDER, 0);
    applyStimulus(0, 1, 1'b1, K_ADDR, 0, K_BORDER, 0);
    applyStimulus(1, 1, 1'b1, K_ADDR, 0, K_BORDER, 0);
    applyStimulus(2, 1, 1'b1, K_ADDR, 1, K_BORDER, 0);
    for (int y = 2; y <= 239; y++) begin
      if (y == 100) scale_sel = 2'd3;
      applyStimulus(0, y, 1'b1, K_ADDR, (y >> 1) * 160, K_BORDER, 0);
    end
    applyStimulus(0, 240, 1'b1, K_BORDER, 0, K_BORDER, 0);
    applyStimulus(0, 479, 1'b0, K_ZERO, 0, K_ZERO, 0);

    // Frame C, select 3 folds to s=2: full-screen window for A, clipped window for B.
    for (int y = 0; y <= 478; y++)
      applyStimulus(0, y, 1'b1, K_ADDR, (y >> 2) * 160, K_BORDER, 0);
    for (int x = 0; x <= 639; x++)
      applyStimulus(x, 479, 1'b1, K_ADDR, 19040 + (x >> 2),
                    (x < 100) ? K_BORDER : K_ADDR, 17120 + ((x - 100) >> 2));
    scale_sel = 2'd0;

    // Frame D, s=0, reset pulse at line 60.
    for (int y = 0; y <= 59; y++)
      applyStimulus(0, y, 1'b1, K_ADDR, y * 160, K_BORDER, 0);
    applyStimulus(0, 60, 1'b1, K_NONE, 0, K_NONE, 0);
    rst = 1'b1;
    applyStimulus(1, 60, 1'b1, K_ZERO, 0, K_ZERO, 0);
    check_reset_state("mid-frame reset");
    rst = 1'b0;
    applyStimulus(0, 61, 1'b1, K_BORDER, 0, K_BORDER, 0);
    applyStimulus(0, 62, 1'b1, K_BORDER, 0, K_BORDER, 0);
    applyStimulus(0, 479, 1'b0, K_ZERO, 0, K_ZERO, 0);

    // Frame E realigns after the reset.
    for (int x = 0; x <= 3; x++)
      applyStimulus(x, 0, 1'b1, K_ADDR, x, K_BORDER, 0);
    for (int y = 1; y <= 118; y++)
      applyStimulus(0, y, 1'b1, K_ADDR, y * 160, K_BORDER, 0);
    for (int x = 0; x <= 159; x++)
      applyStimulus(x, 119, 1'b1, K_ADDR, 19040 + x,
                    (x >= 100) ? K_ADDR : K_BORDER, 11040 + x - 100);
    applyStimulus(0, 119, 1'b0, K_NONE, 0, K_NONE, 0);
    applyStimulus(0, 119, 1'b0, K_NONE, 0, K_NONE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scale_reader.md
FB_SCALE_READER -- requirements
Module: fb_scale_reader

Interface
REQ-001 Parameter CAM_W, default 160, frame-buffer image width in pixels.
REQ-002 Parameter CAM_H, default 120, frame-buffer image height in pixels.
REQ-003 Parameter AW, default 15, RAM address width; CAM_W*CAM_H SHALL be at most 2**AW.
REQ-004 Parameter DW, default 8, pixel width (RGB332).
REQ-005 Parameter OFFSET_X, default 0, window left edge in display pixels.
REQ-006 Parameter OFFSET_Y, default 0, window top edge in display lines.
REQ-007 clk  input  1  pixel clock (25 MHz VGA domain); one clock; all logic on the rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 pos_x  input  10  display column of the next pixel, from the VGA driver.
REQ-010 pos_y  input  9  display line of the next pixel, from the VGA driver.
REQ-011 pos_valid  input  1  high while pos_x/pos_y lie in the 640x480 active area.
REQ-012 scale_sel  input  2  upscale shift s (factor 2**s); value 3 is treated as 2.
REQ-013 border_color  input  DW  color driven for active pixels outside the window.
REQ-014 ram_addr  output  AW  registered read address to the dual-port RAM.
REQ-015 ram_data  input  DW  RAM read data, valid one clk after ram_addr.
REQ-016 pixel_out  output  DW  pixel to the VGA driver.
REQ-017 pixel_valid  output  1  pixel_out corresponds to an active position.

Function
REQ-018 Window: pos_x in [OFFSET_X, OFFSET_X + (CAM_W<<s)) and pos_y in [OFFSET_Y, OFFSET_Y + (CAM_H<<s)), with s the latched scale.
REQ-019 Address SHALL be row_base + col, computed incrementally with no multiplier; row_base advances by CAM_W, col by 1.
REQ-020 col SHALL reset to 0 at pos_x == OFFSET_X and increment after every 2**s window pixels on a line.
REQ-021 A new line SHALL be detected when pos_y differs from its value registered on the previous clk.
REQ-022 On a new line inside the window, the line sub-counter SHALL increment; row_base SHALL advance by CAM_W when the sub-counter wraps from 2**s-1 to 0.
REQ-023 Frame start is pos_y == 0 with the previous pos_y != 0; at frame start row_base, the sub-counters and col SHALL clear and scale_sel SHALL be latched.
REQ-024 scale_sel changes mid-frame SHALL have no effect until the next frame start.
REQ-025 ram_addr SHALL update one clk after the position is presented; it SHALL hold its last value outside the window.
REQ-026 pixel_out/pixel_valid latency from pos_x/pos_y/pos_valid SHALL be exactly 2 clk; the in-window and valid flags are pipelined to match.
REQ-027 pixel_out = ram_data when the delayed flags are valid and in-window, border_color when valid and out-of-window, 0 when not valid.
REQ-028 The address SHALL never exceed CAM_W*CAM_H-1; the window bounds guarantee this, and a failing assertion flags any violation.
REQ-029 When the window exceeds 640x480, it SHALL be clipped silently with no address wrap.

Reset
REQ-030 While rst is high, ram_addr = 0, pixel_out = 0, pixel_valid = 0, the latched scale = 0, and row_base, col, sub-counters and pipeline flags = 0.
REQ-031 Reset asserted mid-frame SHALL take effect on the next edge; after release, output SHALL be border/0 until the next frame start realigns the counters.

Structure
REQ-032 The shared package SHALL hold the VGA active-area constants (640, 480) and the RGB332 color constants.
REQ-033 One sub-module, fb_axis_counter (column or row counter with programmable 2**s sub-divider), SHALL be instantiated twice (x and y).
REQ-034 The RAM and the VGA driver SHALL remain outside this block.

Verification
REQ-035 Defaults, s=0, full frame -> line 0 px 0..159 give addr 0..159; line 1 px 0 gives addr 160; line 119 px 159 gives addr 19199; 2-clk latency.
REQ-036 s=1 -> px 0,1 give addr 0; px 2 gives 1; lines 0 and 1 share row_base 0; line 2 gives row_base 160; px 320 gives border_color.
REQ-037 s=2, OFFSET_X=0, OFFSET_Y=0 -> 640x480 window fully covered; last pixel addr 19199; border is never emitted.
REQ-038 OFFSET_X=100, OFFSET_Y=50, s=0 -> px(99,50) = border; px(100,50) = addr 0; px(260,50) = border; line 170 = border.
REQ-039 scale_sel changes 0 to 1 at line 200 -> the current frame stays s=0; the next frame uses s=1.
REQ-040 rst pulse at line 60 -> outputs 0 on the next clk; after release, border until the frame start; the next frame's addresses match REQ-035.
